// File: rtl/uart_regs.sv
// uart_regs: 16550-style UART register block with 16-deep TX/RX FIFOs and a baud generator.
// Optional feature: define UART_LOOPBACK_EN to enable MCR[4] internal loopback.
module uart_regs (
   input  logic       clk,
   input  logic       wb_rst_i,
   input  logic [2:0] wb_addr_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   input  logic       wb_we_i,
   input  logic       wb_re_i,
   input  logic [3:0] modem_inputs,
   input  logic       srx_pad_i,
   output logic       stx_pad_o,
   output logic       rts_pad_o,
   output logic       dtr_pad_o,
   output logic       int_o
);

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

   function automatic logic f_parity(input logic [7:0] data, input logic stick,
                                     input logic even);
      if (stick) return ~even;
      return even ? ^data : ~^data;
   endfunction

   // Configuration registers
   logic [3:0]  r_ier;
   logic [7:0]  r_lcr, r_scr, r_dll, r_dlm;
   logic [4:0]  r_mcr;
   logic [1:0]  r_rx_trig;
   logic        r_oe, r_thre;
   logic [3:0]  r_msr_prev, r_msr_delta;
   logic [15:0] r_baud_cnt;

   logic        w_dlab, w_loop, w_tick;
   logic        w_wr_thr, w_wr_dll, w_wr_dlm, w_wr_ier, w_wr_fcr, w_wr_lcr, w_wr_mcr, w_wr_scr;
   logic        w_rd_rbr, w_rd_iir, w_rd_lsr, w_rd_msr;
   logic [15:0] w_div;
   logic [7:0]  w_len_mask, w_lsr, w_iir;
   logic [2:0]  w_last_bit, w_int_id;
   logic        w_int_pend;
   logic [3:0]  w_msr_hi, w_msr_chg;
   logic [4:0]  w_trig;

`ifdef UART_LOOPBACK_EN
   localparam logic [4:0] McrMask = 5'h1F;
   assign w_loop = r_mcr[4];
`else
   localparam logic [4:0] McrMask = 5'h0F;
   assign w_loop = 1'b0;
`endif

   assign w_dlab   = r_lcr[7];
   assign w_wr_thr = wb_we_i && (wb_addr_i == 3'd0) && !w_dlab;
   assign w_wr_dll = wb_we_i && (wb_addr_i == 3'd0) && w_dlab;
   assign w_wr_ier = wb_we_i && (wb_addr_i == 3'd1) && !w_dlab;
   assign w_wr_dlm = wb_we_i && (wb_addr_i == 3'd1) && w_dlab;
   assign w_wr_fcr = wb_we_i && (wb_addr_i == 3'd2);
   assign w_wr_lcr = wb_we_i && (wb_addr_i == 3'd3);
   assign w_wr_mcr = wb_we_i && (wb_addr_i == 3'd4);
   assign w_wr_scr = wb_we_i && (wb_addr_i == 3'd7);
   assign w_rd_rbr = wb_re_i && (wb_addr_i == 3'd0) && !w_dlab;
   assign w_rd_iir = wb_re_i && (wb_addr_i == 3'd2);
   assign w_rd_lsr = wb_re_i && (wb_addr_i == 3'd5);
   assign w_rd_msr = wb_re_i && (wb_addr_i == 3'd6);

   assign w_len_mask = 8'hFF >> (2'd3 - r_lcr[1:0]);
   assign w_last_bit = 3'd4 + {1'b0, r_lcr[1:0]};

   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         r_ier     <= '0;
         r_lcr     <= 8'h03;
         r_mcr     <= '0;
         r_scr     <= '0;
         r_dll     <= '0;
         r_dlm     <= '0;
         r_rx_trig <= '0;
      end else begin
         if (w_wr_ier) r_ier <= wb_dat_i[3:0];
         if (w_wr_lcr) r_lcr <= wb_dat_i;
         if (w_wr_mcr) r_mcr <= wb_dat_i[4:0] & McrMask;
         if (w_wr_scr) r_scr <= wb_dat_i;
         if (w_wr_dll) r_dll <= wb_dat_i;
         if (w_wr_dlm) r_dlm <= wb_dat_i;
         if (w_wr_fcr) r_rx_trig <= wb_dat_i[7:6];
      end
   end

   // Baud generator: a divisor write restarts the count so the new rate starts cleanly
   assign w_div  = {r_dlm, r_dll};
   assign w_tick = (w_div != 16'd0) && (r_baud_cnt >= w_div - 16'd1);

   always_ff @(posedge clk) begin
      if (wb_rst_i || w_wr_dll || w_wr_dlm || w_tick || (w_div == 16'd0)) r_baud_cnt <= '0;
      else r_baud_cnt <= r_baud_cnt + 16'd1;
   end

   // TX FIFO
   logic [7:0] r_tx_mem [16];
   logic [3:0] r_tx_wp, r_tx_rp;
   logic [4:0] r_tx_cnt, w_tx_cnt_d;
   logic       w_tx_push, w_tx_pop, w_tx_empty, w_tx_full, w_tx_clr;
   logic [7:0] w_tx_head;

   assign w_tx_empty = (r_tx_cnt == 5'd0);
   assign w_tx_full  = (r_tx_cnt == 5'd16);
   assign w_tx_push  = w_wr_thr && !w_tx_full;
   assign w_tx_clr   = w_wr_fcr && wb_dat_i[2];
   assign w_tx_head  = r_tx_mem[r_tx_rp] & w_len_mask;

   always_comb begin
      w_tx_cnt_d = r_tx_cnt;
      if (w_tx_clr) w_tx_cnt_d = '0;
      else if (w_tx_push && !w_tx_pop) w_tx_cnt_d = r_tx_cnt + 5'd1;
      else if (!w_tx_push && w_tx_pop) w_tx_cnt_d = r_tx_cnt - 5'd1;
   end

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= wb_dat_i;
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i || w_tx_clr) begin
         r_tx_wp <= '0;
         r_tx_rp <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 4'd1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 4'd1;
      end
      r_tx_cnt <= wb_rst_i ? 5'd0 : w_tx_cnt_d;
   end

   // Transmitter
   tx_state_e  r_tx_state, w_tx_state_d;
   logic [7:0] r_tx_shift;
   logic [3:0] r_tx_tick;
   logic [2:0] r_tx_bit;
   logic       r_tx_par, r_tx_stop, w_tx_bit_end, w_tx_serial, w_tx_line;

   assign w_tx_bit_end = w_tick && (r_tx_tick == 4'hF);

   always_ff @(posedge clk) begin
      if (wb_rst_i) r_tx_state <= TxIdle;
      else          r_tx_state <= w_tx_state_d;
   end

   always_comb begin
      w_tx_state_d = r_tx_state;
      case (r_tx_state)
         TxIdle:   if (!w_tx_empty) w_tx_state_d = TxStart;
         TxStart:  if (w_tx_bit_end) w_tx_state_d = TxData;
         TxData:   if (w_tx_bit_end && (r_tx_bit == w_last_bit))
                      w_tx_state_d = r_lcr[3] ? TxParity : TxStop;
         TxParity: if (w_tx_bit_end) w_tx_state_d = TxStop;
         TxStop:   if (w_tx_bit_end && (!r_lcr[2] || r_tx_stop)) w_tx_state_d = TxIdle;
         default:  w_tx_state_d = TxIdle;
      endcase
   end

   always_comb begin
      w_tx_pop    = 1'b0;
      w_tx_serial = 1'b1;
      case (r_tx_state)
         TxIdle:   w_tx_pop    = !w_tx_empty;
         TxStart:  w_tx_serial = 1'b0;
         TxData:   w_tx_serial = r_tx_shift[0];
         TxParity: w_tx_serial = r_tx_par;
         default:  w_tx_serial = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
         r_tx_tick  <= '0;
         r_tx_bit   <= '0;
         r_tx_stop  <= 1'b0;
      end else if (w_tx_pop) begin
         r_tx_shift <= w_tx_head;
         r_tx_par   <= f_parity(w_tx_head, r_lcr[5], r_lcr[4]);
         r_tx_tick  <= '0;
         r_tx_bit   <= '0;
         r_tx_stop  <= 1'b0;
      end else if (w_tick) begin
         r_tx_tick <= r_tx_tick + 4'd1;
         if (w_tx_bit_end && (r_tx_state == TxData)) begin
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
         end
         if (w_tx_bit_end && (r_tx_state == TxStop)) r_tx_stop <= 1'b1;
      end
   end

   // Break overrides the line only; the shifter keeps running underneath
   assign w_tx_line = r_lcr[6] ? 1'b0 : w_tx_serial;
   assign stx_pad_o = w_loop ? 1'b1 : w_tx_line;

   // Receiver
   rx_state_e   r_rx_state, w_rx_state_d;
   logic [7:0]  r_rx_shift, w_rx_byte;
   logic [3:0]  r_rx_tick;
   logic [2:0]  r_rx_bit;
   logic        r_rx_par, r_rx_allz, r_rx_prev;
   logic        w_rx_in, w_rx_fall, w_rx_mid, w_rx_push;
   logic [10:0] w_rx_entry;

   assign w_rx_in   = w_loop ? w_tx_line : srx_pad_i;
   assign w_rx_fall = r_rx_prev && !w_rx_in;
   assign w_rx_mid  = w_tick && ((r_rx_state == RxStart) ? (r_rx_tick == 4'd7)
                                                         : (r_rx_tick == 4'd15));
   assign w_rx_byte  = r_rx_shift >> (2'd3 - r_lcr[1:0]);
   assign w_rx_entry = {r_rx_allz && !w_rx_in, !w_rx_in,
                        r_lcr[3] && (r_rx_par != f_parity(w_rx_byte, r_lcr[5], r_lcr[4])),
                        w_rx_byte};

   always_ff @(posedge clk) begin
      if (wb_rst_i) r_rx_state <= RxIdle;
      else          r_rx_state <= w_rx_state_d;
   end

   always_comb begin
      w_rx_state_d = r_rx_state;
      case (r_rx_state)
         RxIdle:   if (w_rx_fall) w_rx_state_d = RxStart;
         RxStart:  if (w_rx_mid) w_rx_state_d = w_rx_in ? RxIdle : RxData;
         RxData:   if (w_rx_mid && (r_rx_bit == w_last_bit))
                      w_rx_state_d = r_lcr[3] ? RxParity : RxStop;
         RxParity: if (w_rx_mid) w_rx_state_d = RxStop;
         RxStop:   if (w_rx_mid) w_rx_state_d = RxIdle;
         default:  w_rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      w_rx_push = 1'b0;
      if (r_rx_state == RxStop) w_rx_push = w_rx_mid;
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         r_rx_tick  <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_par   <= 1'b0;
         r_rx_allz  <= 1'b0;
         r_rx_prev  <= 1'b1;
      end else begin
         r_rx_prev <= w_rx_in;
         if ((r_rx_state == RxIdle) || w_rx_mid) r_rx_tick <= '0;
         else if (w_tick)                        r_rx_tick <= r_rx_tick + 4'd1;
         if (r_rx_state == RxStart) begin
            r_rx_bit  <= '0;
            r_rx_allz <= 1'b1;
         end
         if (w_rx_mid && (r_rx_state == RxData)) begin
            r_rx_shift <= {w_rx_in, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
         if (w_rx_mid && (r_rx_state == RxParity)) r_rx_par <= w_rx_in;
         if (w_rx_mid && w_rx_in && ((r_rx_state == RxData) || (r_rx_state == RxParity)))
            r_rx_allz <= 1'b0;
      end
   end

   // RX FIFO; r_rx_err_cnt tracks how many stored entries carry PE/FE/BI
   logic [10:0] r_rx_mem [16];
   logic [3:0]  r_rx_wp, r_rx_rp;
   logic [4:0]  r_rx_cnt, r_rx_err_cnt;
   logic        w_rx_empty, w_rx_full, w_rx_pop, w_rx_accept, w_rx_clr;
   logic [10:0] w_rx_head;
   logic [2:0]  w_head_flags;

   assign w_rx_empty   = (r_rx_cnt == 5'd0);
   assign w_rx_full    = (r_rx_cnt == 5'd16);
   assign w_rx_pop     = w_rd_rbr && !w_rx_empty;
   assign w_rx_accept  = w_rx_push && (!w_rx_full || w_rx_pop);
   assign w_rx_clr     = w_wr_fcr && wb_dat_i[1];
   assign w_rx_head    = r_rx_mem[r_rx_rp];
   assign w_head_flags = w_rx_empty ? 3'b000 : w_rx_head[10:8];

   always_ff @(posedge clk) begin
      if (w_rx_accept) r_rx_mem[r_rx_wp] <= w_rx_entry;
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i || w_rx_clr) begin
         r_rx_wp      <= '0;
         r_rx_rp      <= '0;
         r_rx_cnt     <= '0;
         r_rx_err_cnt <= '0;
      end else begin
         if (w_rx_accept) r_rx_wp <= r_rx_wp + 4'd1;
         if (w_rx_pop)    r_rx_rp <= r_rx_rp + 4'd1;
         r_rx_cnt     <= r_rx_cnt + {4'd0, w_rx_accept} - {4'd0, w_rx_pop};
         r_rx_err_cnt <= r_rx_err_cnt + {4'd0, w_rx_accept && (|w_rx_entry[10:8])}
                                      - {4'd0, w_rx_pop && (|w_rx_head[10:8])};
      end
   end

   always_ff @(posedge clk) begin
      if (wb_rst_i)                                    r_oe <= 1'b0;
      else if (w_rx_push && !w_rx_accept && !w_rx_clr) r_oe <= 1'b1;
      else if (w_rd_lsr)                               r_oe <= 1'b0;
   end

   assign w_lsr = {r_rx_err_cnt != 5'd0, w_tx_empty && (r_tx_state == TxIdle), w_tx_empty,
                   w_head_flags, r_oe, !w_rx_empty};

   // Modem status; deltas raised in the same cycle as an MSR read survive it
   assign w_msr_hi  = w_loop ? {r_mcr[3], r_mcr[2], r_mcr[0], r_mcr[1]}
                             : {modem_inputs[0], modem_inputs[1], modem_inputs[2], modem_inputs[3]};
   assign w_msr_chg = {r_msr_prev[3] ^ w_msr_hi[3], r_msr_prev[2] & ~w_msr_hi[2],
                       r_msr_prev[1] ^ w_msr_hi[1], r_msr_prev[0] ^ w_msr_hi[0]};

   always_ff @(posedge clk) begin
      r_msr_prev <= w_msr_hi;
      if (wb_rst_i) r_msr_delta <= '0;
      else          r_msr_delta <= (w_rd_msr ? 4'b0000 : r_msr_delta) | w_msr_chg;
   end

   // Interrupts
   always_comb begin
      case (r_rx_trig)
         2'd0:    w_trig = 5'd1;
         2'd1:    w_trig = 5'd4;
         2'd2:    w_trig = 5'd8;
         default: w_trig = 5'd14;
      endcase
   end

   always_comb begin
      w_int_id   = 3'b000;
      w_int_pend = 1'b1;
      if (r_ier[2] && (w_lsr[4:1] != 4'd0))           w_int_id = 3'b011;
      else if (r_ier[0] && (r_rx_cnt >= w_trig))      w_int_id = 3'b010;
      else if (r_ier[1] && r_thre)                    w_int_id = 3'b001;
      else if (r_ier[3] && (r_msr_delta != 4'd0))     w_int_id = 3'b000;
      else                                            w_int_pend = 1'b0;
   end

   assign w_iir = {4'b1100, w_int_id, ~w_int_pend};
   assign int_o = w_int_pend;

   always_ff @(posedge clk) begin
      if (wb_rst_i)
         r_thre <= 1'b0;
      else if (w_wr_thr)
         r_thre <= 1'b0;
      else if ((!w_tx_empty && (w_tx_cnt_d == 5'd0)) ||
               (w_wr_ier && wb_dat_i[1] && !r_ier[1] && w_tx_empty))
         r_thre <= 1'b1;
      else if (w_rd_iir && w_int_pend && (w_int_id == 3'b001))
         r_thre <= 1'b0;
   end

   assign rts_pad_o = w_loop ? 1'b0 : r_mcr[1];
   assign dtr_pad_o = w_loop ? 1'b0 : r_mcr[0];

   always_comb begin
      wb_dat_o = 8'h00;
      case (wb_addr_i)
         3'd0:    wb_dat_o = w_dlab ? r_dll : (w_rx_empty ? 8'h00 : w_rx_head[7:0]);
         3'd1:    wb_dat_o = w_dlab ? r_dlm : {4'h0, r_ier};
         3'd2:    wb_dat_o = w_iir;
         3'd3:    wb_dat_o = r_lcr;
         3'd4:    wb_dat_o = {3'b000, r_mcr};
         3'd5:    wb_dat_o = w_lsr;
         3'd6:    wb_dat_o = {w_msr_hi, r_msr_delta};
         default: wb_dat_o = r_scr;
      endcase
   end

endmodule

// File: tb/tb_uart_regs.sv
// tb_uart_regs: scoreboard bench for uart_regs; serial bits and received bytes are queued
// as stimulus is driven and compared when the DUT produces them.
module tb_uart_regs;

   logic       clk = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic [2:0] wb_addr_i = '0;
   logic [7:0] wb_dat_i = '0;
   logic [7:0] wb_dat_o;
   logic       wb_we_i = 1'b0;
   logic       wb_re_i = 1'b0;
   logic [3:0] modem_inputs = '0;
   logic       srx_pad_i = 1'b1;
   logic       stx_pad_o, rts_pad_o, dtr_pad_o, int_o;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;
   logic [7:0]  rx_exp_q[$];
   logic        tx_exp_q[$];

   uart_regs dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .wb_addr_i    (wb_addr_i),
      .wb_dat_i     (wb_dat_i),
      .wb_dat_o     (wb_dat_o),
      .wb_we_i      (wb_we_i),
      .wb_re_i      (wb_re_i),
      .modem_inputs (modem_inputs),
      .srx_pad_i    (srx_pad_i),
      .stx_pad_o    (stx_pad_o),
      .rts_pad_o    (rts_pad_o),
      .dtr_pad_o    (dtr_pad_o),
      .int_o        (int_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      wb_addr_i = a;
      wb_dat_i  = d;
      wb_we_i   = 1'b1;
      @(negedge clk);
      wb_we_i   = 1'b0;
   endtask

   task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      wb_addr_i = a;
      wb_re_i   = 1'b1;
      #1 d = wb_dat_o;
      @(negedge clk);
      wb_re_i   = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
      logic [7:0] d;
      wb_read(a, d);
      check(tag, {24'd0, d}, {24'd0, exp});
   endtask

   task automatic check_rbr();
      logic [7:0] d;
      logic [7:0] exp;
      wb_read(3'd0, d);
      exp = rx_exp_q.pop_front();
      check("rbr", {24'd0, d}, {24'd0, exp});
   endtask

   task automatic set_line(input logic [7:0] lcr);
      wb_write(3'd3, 8'h80 | lcr);
      wb_write(3'd0, 8'h01);
      wb_write(3'd1, 8'h00);
      wb_write(3'd3, lcr);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_en, input logic par_bit);
      @(negedge clk);
      srx_pad_i = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         srx_pad_i = b[i];
         repeat (16) @(negedge clk);
      end
      if (par_en) begin
         srx_pad_i = par_bit;
         repeat (16) @(negedge clk);
      end
      srx_pad_i = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   // Sends one 8N1 byte and checks start-bit width plus mid-bit levels of data and stop
   task automatic tx_frame(input logic [7:0] b);
      int n;
      for (int i = 0; i < 8; i++) tx_exp_q.push_back(b[i]);
      tx_exp_q.push_back(1'b1);
      wb_write(3'd0, b);
      n = 0;
      while (stx_pad_o !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("tx_start_seen", {31'd0, stx_pad_o}, 32'd0);
      n = 0;
      while (stx_pad_o === 1'b0 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("tx_start_len", n, 32'd16);
      for (int i = 0; i < 9; i++) begin
         logic e;
         repeat (7) @(negedge clk);
         e = tx_exp_q.pop_front();
         check($sformatf("tx_bit%0d", i), {31'd0, stx_pad_o}, {31'd0, e});
         repeat (9) @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       stx_low;
      int         n;

      repeat (3) @(negedge clk);
      wb_rst_i = 1'b0;
      check("rst_stx", {31'd0, stx_pad_o}, 32'd1);
      check("rst_rts_dtr", {30'd0, rts_pad_o, dtr_pad_o}, 32'd0);
      check("rst_int", {31'd0, int_o}, 32'd0);
      check_reg("rst_rbr", 3'd0, 8'h00);
      check_reg("rst_ier", 3'd1, 8'h00);
      check_reg("rst_iir", 3'd2, 8'hC1);
      check_reg("rst_lcr", 3'd3, 8'h03);
      check_reg("rst_mcr", 3'd4, 8'h00);
      check_reg("rst_lsr", 3'd5, 8'h60);
      check_reg("rst_msr", 3'd6, 8'h00);
      check_reg("rst_scr", 3'd7, 8'h00);

      wb_write(3'd7, 8'hA5);
      check_reg("scr", 3'd7, 8'hA5);
      set_line(8'h03);
      wb_write(3'd3, 8'h83);
      check_reg("dll", 3'd0, 8'h01);
      wb_write(3'd3, 8'h03);

      wb_write(3'd3, 8'h43);
      check("break_stx", {31'd0, stx_pad_o}, 32'd0);
      wb_write(3'd3, 8'h03);
      check("unbreak_stx", {31'd0, stx_pad_o}, 32'd1);

      tx_frame(8'h55);
      check_reg("lsr_after_tx", 3'd5, 8'h60);

      wb_write(3'd1, 8'h02);
      check("thre_int", {31'd0, int_o}, 32'd1);
      check_reg("iir_thre", 3'd2, 8'hC2);
      check("thre_int_clr", {31'd0, int_o}, 32'd0);
      check_reg("iir_after_thre", 3'd2, 8'hC1);
      wb_write(3'd1, 8'h00);

      wb_write(3'd3, 8'h1B);
      rx_exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, ^8'hA5);
      check_reg("lsr_rx_ok", 3'd5, 8'h61);
      check_rbr();
      check_reg("lsr_rx_empty", 3'd5, 8'h60);
      check_reg("rbr_empty", 3'd0, 8'h00);

      wb_write(3'd1, 8'h04);
      rx_exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, ~(^8'hA5));
      check("pe_int", {31'd0, int_o}, 32'd1);
      check_reg("iir_pe", 3'd2, 8'hC6);
      check_reg("lsr_pe", 3'd5, 8'hE5);
      check_rbr();
      check_reg("lsr_pe_pop", 3'd5, 8'h60);
      check("pe_int_clr", {31'd0, int_o}, 32'd0);
      wb_write(3'd1, 8'h00);

      wb_write(3'd3, 8'h03);
      for (int i = 0; i < 17; i++) begin
         logic [7:0] b;
         b = 8'(8'h10 + i * 7);
         if (i < 16) rx_exp_q.push_back(b);
         send_frame(b, 1'b0, 1'b0);
      end
      check_reg("lsr_oe", 3'd5, 8'h63);
      check_reg("lsr_oe_clr", 3'd5, 8'h61);
      wb_write(3'd1, 8'h01);
      wb_write(3'd2, 8'hC0);
      check_reg("iir_rx_trig", 3'd2, 8'hC4);
      for (int i = 0; i < 3; i++) check_rbr();
      check_reg("iir_below_trig", 3'd2, 8'hC1);
      for (int i = 0; i < 13; i++) check_rbr();
      check_reg("lsr_drained", 3'd5, 8'h60);
      wb_write(3'd1, 8'h00);
      wb_write(3'd2, 8'h00);

      modem_inputs = 4'b1000;
      check_reg("msr_cts", 3'd6, 8'h11);
      check_reg("msr_cts_clr", 3'd6, 8'h10);
      wb_write(3'd1, 8'h08);
      modem_inputs = 4'b1010;
      check_reg("msr_ri_rise", 3'd6, 8'h50);
      modem_inputs = 4'b1000;
      @(negedge clk);
      check("ms_int", {31'd0, int_o}, 32'd1);
      check_reg("iir_ms", 3'd2, 8'hC0);
      check_reg("msr_ri_fall", 3'd6, 8'h14);
      check("ms_int_clr", {31'd0, int_o}, 32'd0);
      wb_write(3'd1, 8'h00);
      modem_inputs = 4'b0000;
      check_reg("msr_cts_drop", 3'd6, 8'h01);

      wb_write(3'd4, 8'h03);
      check("mcr_pads", {30'd0, rts_pad_o, dtr_pad_o}, 32'd3);
      wb_write(3'd4, 8'h13);
`ifdef UART_LOOPBACK_EN
      check_reg("mcr_loop", 3'd4, 8'h13);
      check("loop_pads", {30'd0, rts_pad_o, dtr_pad_o}, 32'd0);
      d = 8'h00;
      wb_read(3'd6, d);
      check("loop_msr_hi", {28'd0, d[7:4]}, 32'd3);
      rx_exp_q.push_back(8'h3C);
      wb_write(3'd0, 8'h3C);
      stx_low = 1'b0;
      n = 0;
      d = 8'h00;
      while (d[0] !== 1'b1 && n < 400) begin
         if (stx_pad_o !== 1'b1) stx_low = 1'b1;
         wb_read(3'd5, d);
         n++;
      end
      check("loop_rx_ready", {31'd0, d[0]}, 32'd1);
      check("loop_stx_idle", {31'd0, stx_low}, 32'd0);
      check_rbr();
`else
      check_reg("mcr_no_loop", 3'd4, 8'h03);
      check("no_loop_pads", {30'd0, rts_pad_o, dtr_pad_o}, 32'd3);
      stx_low = 1'b0;
      n = 0;
      d = 8'h00;
`endif
      wb_write(3'd4, 8'h00);

      wb_write(3'd0, 8'h00);
      n = 0;
      while (stx_pad_o !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      check("midframe_low", {31'd0, stx_pad_o}, 32'd0);
      wb_rst_i = 1'b1;
      @(negedge clk);
      check("rst_midframe_stx", {31'd0, stx_pad_o}, 32'd1);
      wb_rst_i = 1'b0;
      check_reg("rst_midframe_lsr", 3'd5, 8'h60);
      check_reg("rst_midframe_lcr", 3'd3, 8'h03);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/uart_regs.md
UART_REGS -- requirements
Module: uart_regs

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 wb_rst_i  input  1  synchronous active-high reset.
REQ-004 wb_addr_i  input  3  register index 0-7.
REQ-005 wb_dat_i  input  8  write data; sampled only while wb_we_i=1.
REQ-006 wb_dat_o  output  8  read data; combinational from wb_addr_i and current state.
REQ-007 wb_we_i / wb_re_i  input  1 each  one-cycle write / read strobes; side effects occur on the strobe cycle.
REQ-008 modem_inputs  input  4  {CTS, DSR, RI, DCD}, active-high.
REQ-009 srx_pad_i  input  1  serial receive, idle high.
REQ-010 stx_pad_o  output  1  serial transmit, idle high.
REQ-011 rts_pad_o / dtr_pad_o  output  1 each  equal to MCR[1] / MCR[0].
REQ-012 int_o  output  1  high while any enabled interrupt is pending.

Function
REQ-013 Register map: 0 RBR(read)/THR(write); 1 IER[3:0]; 2 IIR(read)/FCR(write); 3 LCR; 4 MCR[4:0]; 5 LSR (read-only); 6 MSR (read-only); 7 SCR. When LCR[7]=1 (DLAB), addresses 0/1 access DLL/DLM instead.
REQ-014 Baud tick: 16-bit counter with divisor {DLM,DLL}; one tick every divisor clocks; divisor 0 stops the tick; a DLL/DLM write restarts the counter.
REQ-015 Bit time = 16 ticks; frame = start(0), 5-8 data bits LSB first (LCR[1:0]+5), optional parity (LCR[3]; even if LCR[4]; stick if LCR[5]: parity = ~LCR[4]), stop bits 1, or 2 when LCR[2]=1.
REQ-016 LCR[6]=1 forces stx_pad_o=0 without disturbing the transmitter state.
REQ-017 TX FIFO 16x8; a THR write pushes; a write when full is dropped; the transmitter loads the next byte one clock after the stop bit(s) complete.
REQ-018 RX FIFO 16x11 (byte plus PE, FE, BI); a start is detected on a falling edge of srx_pad_i; the line is re-sampled at tick 8 and the start is aborted if high; data, parity and stop are sampled at 16-tick intervals.
REQ-019 Received byte with full RX FIFO: byte dropped, LSR[1] OE set; a simultaneous receiver push and RBR pop both take effect.
REQ-020 An RBR read pops the FIFO; a read while empty returns 0x00 with no effect.
REQ-021 LSR: [0] RX not empty, [1] OE, [2] PE, [3] FE, [4] BI of head entry, [5] TX FIFO empty, [6] TX FIFO empty and shifter idle, [7] any FIFO entry with PE/FE/BI. Reading LSR clears bit 1 only.
REQ-022 FCR write: bit1 clears RX FIFO, bit2 clears TX FIFO, bits[7:6] set RX trigger 1/4/8/14.
REQ-023 MSR[7:4] = {DCD, RI, DSR, CTS}. Deltas: [0] CTS change, [1] DSR change, [2] RI falling, [3] DCD change. Deltas are cleared by an MSR read; a change in the same cycle as the read stays set.
REQ-024 Interrupt priority, highest first, IIR[3:1]: 011 line status (IER[2], LSR[4:1]≠0); 010 RX data (IER[0], RX count ≥ trigger); 001 THR empty (IER[1], THRE latch); 000 modem (IER[3], MSR[3:0]≠0).
REQ-025 IIR = {2'b11, 2'b00, id[2:0], ~pending}; int_o = pending.
REQ-026 THRE latch: set when the TX FIFO becomes empty or IER[1] goes 0→1 with FIFO empty; cleared by a THR write, or by an IIR read while THRE is the reported source.

Reset
REQ-027 On reset: IER=0, IIR=0xC1, LCR=0x03, MCR=0, SCR=0, DLL=DLM=0, LSR=0x60, MSR deltas=0, FIFOs empty, RX trigger 1, stx_pad_o=1, rts_pad_o=0, dtr_pad_o=0, int_o=0.
REQ-028 Reset mid-frame aborts TX/RX immediately; stx_pad_o is 1 in the next cycle.

Configuration
REQ-029 With UART_LOOPBACK_EN defined, MCR[4]=1 selects loopback: TX serial output feeds the receiver, stx_pad_o=1, rts_pad_o=dtr_pad_o=0, MSR[7:4]={MCR[3],MCR[2],MCR[0],MCR[1]}. Without the macro, MCR[4] reads 0 and has no effect.

Verification
REQ-030 Reset, then read all 8 addresses -> IIR 0xC1, LCR 0x03, LSR 0x60, others 0x00; stx_pad_o=1.
REQ-031 DL=1, LCR=0x03, write THR 0x55 -> stx 0, then 1,0,1,0,1,0,1,0 LSB first, then 1, each level held 16 clocks; LSR[6] returns to 1.
REQ-032 DL=1, LCR=0x1B (even parity), drive frame 0xA5 on srx_pad_i -> LSR[0]=1, RBR=0xA5, LSR[2]=0; repeat with wrong parity -> LSR[2]=1, IIR=0xC6 when IER=0x04.
REQ-033 Receive 17 bytes without reading -> LSR[1]=1; first 16 bytes read back in order; LSR read clears OE.
REQ-034 IER=0x02 with empty TX FIFO -> int_o=1, IIR=0xC2; read IIR -> int_o=0 next cycle.
REQ-035 UART_LOOPBACK_EN, MCR=0x13, THR 0x3C -> RBR 0x3C, stx_pad_o stays 1, MSR[4]=1.
